// File: rtl/dcache_assoc.sv
// Set-associative, write-through, write-allocate data cache with true-LRU replacement.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
package dcache_assoc_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;
endpackage

// state     | meaning
// IDLE      | waiting for an LSQ request; hits are resolved here
// FILL_REQ  | issuing BUS_LOAD until the bus accepts it
// FILL_WAIT | waiting for the returned line with the latched tag
// STORE_REQ | issuing BUS_STORE with the merged line until accepted
// RESP      | presenting the load result to the LSQ
module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2,
  parameter int MEM_TAG_W = 4,
  parameter int LINE_BITS = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          proc2Dcache_addr,
  input  logic [31:0]          proc2Dcache_data,
  input  logic                 rd_mem,
  input  logic                 wr_mem,
  input  logic [2:0]           proc2Dmem_size,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [LINE_BITS-1:0] mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output bus_command_t         proc2mem_command,
  output logic [31:0]          proc2mem_addr,
  output logic [LINE_BITS-1:0] proc2mem_data,
  output logic [31:0]          data2lsq,
  output logic                 rd_valid_o,
  output logic                 wr_valid_o,
  output logic                 busy_o
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - 3 - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int NB    = LINE_BITS / 8;

  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, STORE_REQ, RESP} state_t;

  state_t               state_q, state_d;
  logic [31:0]          req_addr_q, req_addr_d;
  logic [31:0]          req_data_q, req_data_d;
  logic [2:0]           req_size_q, req_size_d;
  logic                 req_load_q, req_load_d;
  logic [MEM_TAG_W-1:0] mtag_q, mtag_d;
  logic [LINE_BITS-1:0] merged_q, merged_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]     tags_q  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [WAY_W-1:0]     age_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]     new_age [NUM_WAYS];

  logic [31:0]          sel_addr, sel_data;
  logic [2:0]           sel_size, sel_off;
  logic [IDX_W-1:0]     sel_idx;
  logic [TAG_W-1:0]     sel_tag;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way, victim, line_way, lru_way;
  logic [LINE_BITS-1:0] hit_line, line_wdata;
  logic                 line_we, fill, lru_we;

  function automatic logic [31:0] extract(input logic [LINE_BITS-1:0] line,
                                          input logic [2:0] off, input logic [2:0] size);
    logic [LINE_BITS-1:0] sh;
    logic [31:0]          res;
    sh = line >> {off, 3'b000};
    case (size[1:0])
      2'd0:    res = size[2] ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    res = size[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  // Only the size-masked bytes of the right-aligned store data reach the line.
  function automatic logic [LINE_BITS-1:0] merge(input logic [LINE_BITS-1:0] line,
                                                 input logic [2:0] off, input logic [2:0] size,
                                                 input logic [31:0] data);
    logic [NB-1:0]        bm;
    logic [LINE_BITS-1:0] m, wd;
    case (size[1:0])
      2'd0:    bm = NB'(8'h01);
      2'd1:    bm = NB'(8'h03);
      default: bm = NB'(8'h0F);
    endcase
    bm = bm << off;
    for (int b = 0; b < NB; b++) m[b*8 +: 8] = {8{bm[b]}};
    wd = LINE_BITS'(data) << {off, 3'b000};
    return (line & ~m) | (wd & m);
  endfunction

  assign sel_addr = (state_q == IDLE) ? proc2Dcache_addr : req_addr_q;
  assign sel_data = (state_q == IDLE) ? proc2Dcache_data : req_data_q;
  assign sel_size = (state_q == IDLE) ? proc2Dmem_size   : req_size_q;
  assign sel_off  = sel_addr[2:0];
  assign sel_idx  = sel_addr[3 +: IDX_W];
  assign sel_tag  = sel_addr[31 -: TAG_W];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[sel_idx][w] && tags_q[sel_idx][w] == sel_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line = data_q[sel_idx][hit_way];

  always_comb begin
    logic found;
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_q[sel_idx][w]) begin
        found  = 1'b1;
        victim = WAY_W'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[sel_idx][w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      new_age[w] = age_q[sel_idx][w];
      if (WAY_W'(w) == lru_way) new_age[w] = '0;
      else if (age_q[sel_idx][w] < age_q[sel_idx][lru_way]) new_age[w] = age_q[sel_idx][w] + WAY_W'(1);
    end
  end

  always_comb begin
    state_d          = state_q;
    req_addr_d       = req_addr_q;
    req_data_d       = req_data_q;
    req_size_d       = req_size_q;
    req_load_d       = req_load_q;
    mtag_d           = mtag_q;
    merged_d         = merged_q;
    rdata_d          = rdata_q;
    line_we          = 1'b0;
    fill             = 1'b0;
    line_way         = '0;
    line_wdata       = '0;
    lru_we           = 1'b0;
    lru_way          = '0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    wr_valid_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_mem || wr_mem) begin
          req_addr_d = proc2Dcache_addr;
          req_data_d = proc2Dcache_data;
          req_size_d = proc2Dmem_size;
          req_load_d = rd_mem;
          if (hit) begin
            lru_we  = 1'b1;
            lru_way = hit_way;
            if (rd_mem) begin
              rdata_d = extract(hit_line, sel_off, sel_size);
              state_d = RESP;
            end else begin
              line_we    = 1'b1;
              line_way   = hit_way;
              line_wdata = merge(hit_line, sel_off, sel_size, sel_data);
              merged_d   = line_wdata;
              state_d    = STORE_REQ;
            end
          end else begin
            state_d = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = {req_addr_q[31:3], 3'b000};
        if (mem2proc_response != '0) begin
          mtag_d  = mem2proc_response;
          state_d = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (mtag_q != '0 && mem2proc_tag == mtag_q) begin
          fill       = 1'b1;
          line_we    = 1'b1;
          line_way   = victim;
          line_wdata = mem2proc_data;
          lru_we     = 1'b1;
          lru_way    = victim;
          mtag_d     = '0;
          if (req_load_q) begin
            rdata_d = extract(mem2proc_data, sel_off, sel_size);
            state_d = RESP;
          end else begin
            line_wdata = merge(mem2proc_data, sel_off, sel_size, sel_data);
            merged_d   = line_wdata;
            state_d    = STORE_REQ;
          end
        end
      end
      STORE_REQ: begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = {req_addr_q[31:3], 3'b000};
        proc2mem_data    = merged_q;
        if (mem2proc_response != '0) begin
          wr_valid_o = 1'b1;
          state_d    = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_size_q <= '0;
      req_load_q <= 1'b0;
      mtag_q     <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_size_q <= req_size_d;
      req_load_q <= req_load_d;
      mtag_q     <= mtag_d;
      merged_q   <= merged_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (line_we) begin
      data_q[sel_idx][line_way] <= line_wdata;
      if (fill) tags_q[sel_idx][line_way] <= sel_tag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (fill) valid_q[sel_idx][line_way] <= 1'b1;
      if (lru_we) begin
        for (int w = 0; w < NUM_WAYS; w++) age_q[sel_idx][w] <= new_age[w];
      end
    end
  end

  assign rd_valid_o = (state_q == RESP);
  assign data2lsq   = rdata_q;
  assign busy_o     = (state_q != IDLE);

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == IDLE && (rd_mem || wr_mem)) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: directed requests, a small bus responder and a memory model.
module tb_dcache_assoc;
  import dcache_assoc_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  proc2Dcache_addr, proc2Dcache_data;
  logic         rd_mem, wr_mem;
  logic [2:0]   proc2Dmem_size;
  logic [3:0]   mem2proc_response, mem2proc_tag;
  logic [63:0]  mem2proc_data;
  bus_command_t proc2mem_command;
  logic [31:0]  proc2mem_addr;
  logic [63:0]  proc2mem_data;
  logic [31:0]  data2lsq;
  logic         rd_valid_o, wr_valid_o, busy_o;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  dcache_assoc #(.NUM_SETS(16), .NUM_WAYS(2), .MEM_TAG_W(4), .LINE_BITS(64)) dut (
    .clock(clock), .reset(reset),
    .proc2Dcache_addr(proc2Dcache_addr), .proc2Dcache_data(proc2Dcache_data),
    .rd_mem(rd_mem), .wr_mem(wr_mem), .proc2Dmem_size(proc2Dmem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .data2lsq(data2lsq),
    .rd_valid_o(rd_valid_o), .wr_valid_o(wr_valid_o), .busy_o(busy_o)
`ifdef DCACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bus_command_t cmd;
    logic [31:0]  addr;
    logic [63:0]  data;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [31:0] exp_rd[$];
  logic [63:0] mem_m [logic [31:0]];
  int          checks = 0, errors = 0;
  int          rdv_cnt = 0, wrv_cnt = 0;
  int          cfg_retries = 0, cfg_fill_delay = 2;
  logic [3:0]  cfg_tag = 4'd3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a load result or an accepted bus command.
  always @(negedge clock) begin : monitor
    bus_exp_t e;
    if (!reset) begin
      if (rd_valid_o) begin
        rdv_cnt++;
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got rd_valid_o with data %h expected none", data2lsq);
        end else check("rd_data", data2lsq, exp_rd.pop_front());
      end
      if (wr_valid_o) wrv_cnt++;
      if (proc2mem_command != BUS_NONE && mem2proc_response != 4'd0) begin
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: got cmd %0d addr %h expected none", proc2mem_command, proc2mem_addr);
        end else begin
          e = exp_bus.pop_front();
          check("bus_cmd", proc2mem_command, e.cmd);
          check("bus_addr", proc2mem_addr, e.addr);
          if (e.cmd == BUS_STORE) check("bus_data", proc2mem_data, e.data);
        end
      end
    end
  end

  // Bus responder: accepts after cfg_retries refusals, returns load data cfg_fill_delay cycles later.
  initial begin : responder
    int         retry_left, pend;
    bit         active;
    logic [3:0] ptag;
    logic [63:0] pline;
    retry_left = 0; pend = 0; active = 0; ptag = '0; pline = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    forever begin
      @(posedge clock); #2;
      mem2proc_response = '0;
      mem2proc_tag      = '0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem2proc_tag  = ptag;
          mem2proc_data = pline;
        end
      end
      if (reset) active = 0;
      else if (proc2mem_command != BUS_NONE) begin
        if (!active) begin
          active     = 1;
          retry_left = cfg_retries;
        end
        if (retry_left > 0) retry_left--;
        else begin
          active            = 0;
          mem2proc_response = cfg_tag;
          if (proc2mem_command == BUS_LOAD) begin
            ptag  = cfg_tag;
            pline = mem_m.exists(proc2mem_addr) ? mem_m[proc2mem_addr] : 64'h0;
            pend  = cfg_fill_delay;
          end else mem_m[proc2mem_addr] = proc2mem_data;
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] exp, input bit miss, input string name);
    int lat;
    bit seen;
    exp_rd.push_back(exp);
    if (miss) exp_bus.push_back('{cmd: BUS_LOAD, addr: {addr[31:3], 3'b000}, data: 64'h0});
    proc2Dcache_addr = addr;
    proc2Dmem_size   = size;
    rd_mem           = 1'b1;
    lat = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clock);
      lat++;
      seen = rd_valid_o;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no rd_valid_o after %0d cycles expected a pulse", name, lat);
    end else if (miss ? (lat - 1 <= 1) : (lat - 1 != 1)) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles expected %s", name, lat - 1, miss ? "more than 1" : "1");
    end
    @(posedge clock); #1;
    rd_mem = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [63:0] exp_line, input bit miss, input int retries,
                          input string name);
    int cyc, held, wr0;
    bit seen;
    cfg_retries = retries;
    if (miss) exp_bus.push_back('{cmd: BUS_LOAD, addr: {addr[31:3], 3'b000}, data: 64'h0});
    exp_bus.push_back('{cmd: BUS_STORE, addr: {addr[31:3], 3'b000}, data: exp_line});
    wr0 = wrv_cnt;
    proc2Dcache_addr = addr;
    proc2Dcache_data = data;
    proc2Dmem_size   = size;
    wr_mem           = 1'b1;
    cyc = 0; held = 0; seen = 0;
    while (!seen && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (proc2mem_command == BUS_STORE) held++;
      seen = wr_valid_o;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: got no wr_valid_o after %0d cycles expected a pulse", name, cyc);
    end
    check({name, "_held"}, held, retries + 1);
    @(posedge clock); #1;
    wr_mem = 1'b0;
    cfg_retries = 0;
    repeat (2) @(posedge clock);
    #1;
    check({name, "_wr_pulses"}, wrv_cnt - wr0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin : stim
    int rd0;
    reset = 1'b1;
    proc2Dcache_addr = '0; proc2Dcache_data = '0;
    rd_mem = 1'b0; wr_mem = 1'b0; proc2Dmem_size = 3'b010;
    mem_m[32'h100] = 64'h1122334455667788;
    mem_m[32'h000] = 64'hA0A1A2A3A4A5A6A7;
    mem_m[32'h080] = 64'hB0B1B2B3B4B5B6B7;
    mem_m[32'h180] = 64'h0;
    mem_m[32'h200] = 64'hC0C1C2C384858687;

    repeat (2) @(negedge clock);
    check("rst_cmd", proc2mem_command, BUS_NONE);
    check("rst_addr", proc2mem_addr, 32'h0);
    check("rst_data", proc2mem_data, 64'h0);
    check("rst_pulses", {rd_valid_o, wr_valid_o}, 2'b00);
    check("rst_data2lsq", data2lsq, 32'h0);
    check("rst_busy", busy_o, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;

    // cold miss then hit on the same word
    do_load(32'h100, 3'b010, 32'h55667788, 1, "cold_load");
    do_load(32'h100, 3'b010, 32'h55667788, 0, "repeat_hit");
`ifdef DCACHE_STATS_EN
    check("miss_cnt", miss_cnt, 32'd1);
    check("hit_cnt", hit_cnt, 32'd1);
`endif

    // sub-word extraction, little-endian byte offsets
    do_load(32'h100, 3'b000, 32'hFFFFFF88, 0, "byte_signed");
    do_load(32'h100, 3'b100, 32'h00000088, 0, "byte_unsigned");
    do_load(32'h107, 3'b000, 32'h00000011, 0, "byte_top");
    do_load(32'h106, 3'b001, 32'h00001122, 0, "half_top");
    do_load(32'h104, 3'b101, 32'h00003344, 0, "half_unsigned");

    // store hit with two refusals, then read back from the cache
    cfg_tag = 4'd2;
    do_store(32'h102, 3'b001, 32'h0000BEEF, 64'h11223344BEEF7788, 0, 2, "store_hit");
    do_load(32'h102, 3'b001, 32'hFFFFBEEF, 0, "half_neg");
    do_load(32'h102, 3'b101, 32'h0000BEEF, 0, "half_zext");

    // store miss: allocate, merge one byte, upper data bits discarded
    do_store(32'h183, 3'b000, 32'h123456A5, 64'h00000000A5000000, 1, 0, "store_miss");
    do_load(32'h180, 3'b010, 32'hA5000000, 0, "store_miss_rb");

    // LRU eviction in set 0
    pulse_reset();
    cfg_tag = 4'd3;
    do_load(32'h000, 3'b010, 32'hA4A5A6A7, 1, "lru_a");
    cfg_retries = 1;
    do_load(32'h080, 3'b010, 32'hB4B5B6B7, 1, "lru_b");
    cfg_retries = 0;
    do_load(32'h000, 3'b010, 32'hA4A5A6A7, 0, "lru_a_hit");
    do_load(32'h100, 3'b010, 32'hBEEF7788, 1, "lru_c");
    do_load(32'h000, 3'b010, 32'hA4A5A6A7, 0, "lru_a_kept");
    do_load(32'h080, 3'b010, 32'hB4B5B6B7, 1, "lru_b_evicted");

    // reset while a fill is outstanding; the late tag must be ignored
    cfg_fill_delay = 4;
    exp_bus.push_back('{cmd: BUS_LOAD, addr: 32'h200, data: 64'h0});
    proc2Dcache_addr = 32'h200;
    proc2Dmem_size   = 3'b010;
    rd_mem           = 1'b1;
    begin : wait_accept
      int n;
      n = 0;
      while (!(proc2mem_command == BUS_LOAD && mem2proc_response != 4'd0) && n < 40) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (n >= 40) begin
        errors++;
        $display("FAIL rst_fill_accept: got no accepted BUS_LOAD after %0d cycles expected one", n);
      end
    end
    check("rst_fill_busy", busy_o, 1'b1);
    rd0 = rdv_cnt;
    @(posedge clock); #1;
    reset  = 1'b1;
    rd_mem = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (8) @(negedge clock);
    check("rst_fill_no_rd", rdv_cnt - rd0, 0);
    check("rst_fill_idle", {busy_o, proc2mem_command}, 3'b000);
    @(posedge clock); #1;
    cfg_fill_delay = 2;
    do_load(32'h200, 3'b010, 32'h84858687, 1, "rst_fill_remiss");

    repeat (3) @(negedge clock);
    check("queues_drained", exp_rd.size() + exp_bus.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
